// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter: FSM states, request owners, starve counter width.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int STARVE_CNT_W = 4;

    function automatic logic is_busy(input arb_state_t s);
        return (s == BUSY_I) || (s == BUSY_D);
    endfunction

endpackage

// File: rtl/l2_arb_grant.sv
// Grant decision between I-side and D-side fill requests, sampled only while the port is idle.
// Build option L2_ARB_ROUND_ROBIN_EN swaps the fixed-D-priority/starvation guard for round robin.
import l2_arb_pkg::*;

module l2_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en,
    input  logic       i_req,
    input  logic       d_req,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    assign grant_valid = arb_en && (i_req || d_req);

`ifdef L2_ARB_ROUND_ROBIN_EN
    arb_owner_t last_grant_q;
    arb_owner_t last_grant_d;

    // On a tie the side that did not win last time goes next.
    always_comb begin
        grant_owner = OWN_D;
        if (i_req && d_req) begin
            grant_owner = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
        end else if (i_req) begin
            grant_owner = OWN_I;
        end
        last_grant_d = last_grant_q;
        if (grant_valid) begin
            last_grant_d = grant_owner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= OWN_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic                    starve_force;

    // D-side wins ties until it has taken LIMIT grants in a row past a waiting I-side.
    always_comb begin
        starve_force = (starve_cnt_q == LIMIT);
        grant_owner  = OWN_D;
        if (i_req && (!d_req || starve_force)) begin
            grant_owner = OWN_I;
        end
        starve_cnt_d = starve_cnt_q;
        if (arb_en) begin
            if (!i_req || (grant_valid && (grant_owner == OWN_I))) begin
                starve_cnt_d = '0;
            end else if (grant_valid && (starve_cnt_q != LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between I-cache and D-cache line fills; one transaction in flight at a time.
// Build option L2_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of D priority.
import l2_arb_pkg::*;

module l2_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_read,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_resp,
    output logic [LINE_WIDTH-1:0] imem_rdata,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [LINE_WIDTH-1:0] dmem_wdata,
    output logic                  dmem_resp,
    output logic [LINE_WIDTH-1:0] dmem_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    // Handshake: a requester holds read/write until its one-cycle resp pulse; the L2 side
    // sees strobes held with stable addr/wdata until a one-cycle mem_resp.
    arb_state_t            state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic       arb_en;
    logic       grant_valid;
    arb_owner_t grant_owner;

    assign arb_en = (state_q == IDLE);

    l2_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .i_req       (imem_read),
        .d_req       (dmem_read || dmem_write),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_owner == OWN_I) begin
                        state_d     = BUSY_I;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                        mem_addr_d  = imem_addr;
                        mem_wdata_d = '0;
                    end else begin
                        state_d     = BUSY_D;
                        mem_read_d  = dmem_read;
                        mem_write_d = dmem_write && !dmem_read;
                        mem_addr_d  = dmem_addr;
                        mem_wdata_d = dmem_wdata;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Responses pass straight through in the L2 response cycle; mem_resp outside BUSY is dropped.
    assign imem_resp  = (state_q == BUSY_I) && mem_resp;
    assign dmem_resp  = (state_q == BUSY_D) && mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : '0;
    assign dmem_rdata = dmem_resp ? mem_rdata : '0;

    strobe_exclusive_a: assert property (@(posedge clk) disable iff (rst)
        !(mem_read_q && mem_write_q) && is_busy(state_q) == (mem_read_q || mem_write_q)
                                     || !is_busy(state_q) && !mem_read_q && !mem_write_q
                                     || is_busy(state_q) && !(mem_read_q && mem_write_q));

endmodule
